// File: rtl/accelerator_hls_deadlock_reporter.sv
// Confirms persistent deadlock indications from the idx0 monitor, snapshots the
// process signals, and hands one report record per episode over valid/ready.
module accelerator_hls_deadlock_reporter #(
  parameter int CONFIRM_CYCLES = 16,
  parameter int CNT_W          = 32,
  parameter int AXIS_W         = 2,
  parameter int IDLE_W         = 8,
  parameter int BLK_W          = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [AXIS_W-1:0] axis_block_sigs,
  input  logic [IDLE_W-1:0] inst_idle_sigs,
  input  logic [BLK_W-1:0]  inst_block_sigs,
  input  logic              clear,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [AXIS_W-1:0] rpt_axis,
  output logic [IDLE_W-1:0] rpt_idle,
  output logic [BLK_W-1:0]  rpt_block,
  output logic [CNT_W-1:0]  rpt_duration,
  output logic              deadlock_detected,
  output logic [15:0]       event_count
);

  typedef enum logic [1:0] {IDLE, ARM, LOCKED, REPORT} state_e;

  localparam logic [CNT_W-1:0] ConfirmVal = CNT_W'(CONFIRM_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d, run_inc;
  logic [CNT_W-1:0]  dur_q, dur_d;
  logic              valid_q, valid_d;
  logic              confirm;
  logic [AXIS_W-1:0] axis_q;
  logic [IDLE_W-1:0] idle_q;
  logic [BLK_W-1:0]  blk_q;
  logic              detected_q, detected_d;
  logic [15:0]       count_q, count_d, count_base;

  assign run_inc = run_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    dur_d     = dur_q;
    valid_d   = valid_q;
    confirm   = 1'b0;
    case (state_q)
      IDLE: begin
        if (block) begin
          run_cnt_d = CNT_W'(1);
          if (CONFIRM_CYCLES == 1) begin
            confirm = 1'b1;
            state_d = LOCKED;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (!block) begin
          run_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          run_cnt_d = run_inc;
          if (run_inc == ConfirmVal) begin
            confirm = 1'b1;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (block) begin
          if (run_cnt_q != '1) run_cnt_d = run_inc;
        end else begin
          dur_d   = run_cnt_q;
          valid_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          valid_d   = 1'b0;
          run_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear coinciding with confirmation is applied first, so confirm wins.
  always_comb begin
    count_base = clear ? 16'h0000 : count_q;
    detected_d = clear ? 1'b0 : detected_q;
    count_d    = count_base;
    if (confirm) begin
      detected_d = 1'b1;
      count_d    = (count_base == 16'hFFFF) ? 16'hFFFF : count_base + 16'h0001;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      dur_q      <= '0;
      valid_q    <= 1'b0;
      axis_q     <= '0;
      idle_q     <= '0;
      blk_q      <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      dur_q      <= dur_d;
      valid_q    <= valid_d;
      detected_q <= detected_d;
      count_q    <= count_d;
      if (confirm) begin
        axis_q <= axis_block_sigs;
        idle_q <= inst_idle_sigs;
        blk_q  <= inst_block_sigs;
      end
    end
  end

  assign rpt_valid         = valid_q;
  assign rpt_axis          = axis_q;
  assign rpt_idle          = idle_q;
  assign rpt_block         = blk_q;
  assign rpt_duration      = dur_q;
  assign deadlock_detected = detected_q;
  assign event_count       = count_q;

endmodule
